// File: rtl/onchip_mem_stream_loader.sv
// Byte-stream to on-chip memory loader: packs bytes little-endian into 32-bit words,
// writes them from base_addr, then reads the range back and compares checksums.
module onchip_mem_stream_loader #(
    parameter int DEPTH  = 25000,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    // A stream byte transfers on every rising edge where in_valid and in_ready are both 1.
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              ok,
    output logic              err_range,
    output logic [ADDR_W:0]   words_written,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        VERIFY  = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = 1;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   rd_idx;
    logic [1:0]        lane;
    logic [31:0]       word_buf;
    logic [3:0]        be_buf;
    logic [3:0]        last_be;
    logic              last_seen;
    logic [31:0]       wsum;
    logic [31:0]       rsum;
    logic              cap_valid;
    logic              cap_last;
    logic              ok_q;
    logic              err_q;

    logic [ADDR_W:0]   range_sum;
    logic              range_bad;
    logic              byte_take;
    logic              word_end;
    logic              write_final;
    logic              rd_issue;
    logic              rd_final;
    logic [31:0]       cap_word;
    logic [31:0]       rsum_next;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign range_sum   = {1'b0, base_addr} + {1'b0, word_count};
    assign range_bad   = (word_count == '0) || (range_sum > DEPTH_W);
    assign byte_take   = (state == COLLECT) && in_valid;
    assign word_end    = byte_take && ((lane == 2'd3) || in_last);
    assign write_final = last_seen || ((word_idx + ONE_W) == {1'b0, count_q});
    assign rd_issue    = (state == VERIFY) && (rd_idx < word_idx);
    assign rd_final    = (rd_idx == (word_idx - ONE_W));
    // Only the final word can be partial, so only it is masked on readback.
    assign cap_word    = mem_readdata & (cap_last ? be_mask(last_be) : 32'hFFFF_FFFF);
    assign rsum_next   = rsum + cap_word;

    assign ok            = ok_q;
    assign err_range     = err_q;
    assign words_written = word_idx;
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = 4'b0000;
        mem_writedata  = 32'h0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = range_bad ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (word_end) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = base_q + word_idx[ADDR_W-1:0];
                mem_byteenable = be_buf;
                mem_writedata  = word_buf;
                state_next     = write_final ? VERIFY : COLLECT;
            end
            VERIFY: begin
                if (rd_issue) begin
                    mem_chipselect = 1'b1;
                    mem_address    = base_q + rd_idx[ADDR_W-1:0];
                    mem_byteenable = 4'b1111;
                end
                if (cap_valid && cap_last) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q    <= '0;
            count_q   <= '0;
            word_idx  <= '0;
            rd_idx    <= '0;
            lane      <= 2'd0;
            word_buf  <= 32'h0;
            be_buf    <= 4'b0000;
            last_be   <= 4'b0000;
            last_seen <= 1'b0;
            wsum      <= 32'h0;
            rsum      <= 32'h0;
            cap_valid <= 1'b0;
            cap_last  <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ok_q      <= 1'b0;
                        err_q     <= range_bad;
                        base_q    <= base_addr;
                        count_q   <= word_count;
                        word_idx  <= '0;
                        rd_idx    <= '0;
                        lane      <= 2'd0;
                        word_buf  <= 32'h0;
                        be_buf    <= 4'b0000;
                        last_seen <= 1'b0;
                        wsum      <= 32'h0;
                        rsum      <= 32'h0;
                        cap_valid <= 1'b0;
                        cap_last  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (byte_take) begin
                        word_buf[{lane, 3'b000} +: 8] <= in_data;
                        be_buf[lane]                  <= 1'b1;
                        lane                          <= lane + 2'd1;
                        last_seen                     <= in_last;
                    end
                end
                WRITE: begin
                    wsum     <= wsum + word_buf;
                    word_idx <= word_idx + ONE_W;
                    last_be  <= be_buf;
                    word_buf <= 32'h0;
                    be_buf   <= 4'b0000;
                    lane     <= 2'd0;
                end
                VERIFY: begin
                    cap_valid <= rd_issue;
                    cap_last  <= rd_issue && rd_final;
                    if (rd_issue) begin
                        rd_idx <= rd_idx + ONE_W;
                    end
                    if (cap_valid) begin
                        rsum <= rsum_next;
                    end
                    if (cap_valid && cap_last) begin
                        ok_q <= (rsum_next == wsum);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Directed bench for onchip_mem_stream_loader with a 1-cycle-latency memory model
// that can flip one bit on readback of a chosen address.
module tb_onchip_mem_stream_loader;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 25000;
    localparam int W      = ADDR_W + 4 + 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              busy, done, ok, err_range;
    logic [ADDR_W:0]   words_written;
    logic [2:0]        state_dbg;

    int checks = 0;
    int failures = 0;
    int cs_cnt = 0;
    int done_cnt = 0;
    int cs_snap, done_snap;

    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      act_q[$];
    logic [ADDR_W-1:0] exp_rd_q[$];
    logic [ADDR_W-1:0] act_rd_q[$];

    logic              corrupt_en = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;
    logic [31:0]       mem [0:31];
    logic              d_seen, d_ok, d_err;
    logic [ADDR_W:0]   d_ww;

    always #5 clk = ~clk;

    onchip_mem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .busy(busy), .done(done), .ok(ok),
        .err_range(err_range), .words_written(words_written), .state_dbg(state_dbg)
    );

    // Memory model: byte-enabled writes, registered reads, background pattern on reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_A500 | 32'(i);
            mem_readdata <= 32'h0;
        end else if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) mem[mem_address[4:0]][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end else if (mem_chipselect) begin
            mem_readdata <= mem[mem_address[4:0]] ^
                ((corrupt_en && mem_address == corrupt_addr) ? 32'h0000_0100 : 32'h0);
        end
    end

    always @(posedge clk) begin
        if (mem_chipselect) cs_cnt++;
        if (done) done_cnt++;
        if (mem_chipselect && mem_write) act_q.push_back({mem_address, mem_byteenable, mem_writedata});
        if (mem_chipselect && !mem_write) act_rd_q.push_back(mem_address);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete(); act_q.delete(); exp_rd_q.delete(); act_rd_q.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_data = d; in_valid = 1'b1; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%h in_ready=%b required=1", d, in_ready);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        d_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                d_seen = 1'b1; d_ok = ok; d_err = err_range; d_ww = words_written;
                break;
            end
        end
        checks++;
        if (!d_seen) begin
            failures++;
            $display("FAIL done_timeout done=0 required=1 within %0d cycles", budget);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks += 5;
        if ({in_ready, busy, done, ok, err_range, mem_chipselect, mem_write} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=0000000",
                     {in_ready, busy, done, ok, err_range, mem_chipselect, mem_write});
        end
        if (words_written !== '0) begin
            failures++; $display("FAIL reset_words_written got=%0d required=0", words_written);
        end
        if (mem_address !== '0 || mem_writedata !== 32'h0) begin
            failures++; $display("FAIL reset_addr_data got=%h/%h required=0/0", mem_address, mem_writedata);
        end
        if (mem_byteenable !== 4'b0000) begin
            failures++; $display("FAIL reset_byteenable got=%b required=0000", mem_byteenable);
        end
        if (state_dbg !== 3'd0) begin
            failures++; $display("FAIL reset_state got=%0d required=0", state_dbg);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_logs();
        exp_q.push_back({15'd0, 4'hF, 32'h0403_0201});
        exp_q.push_back({15'd1, 4'hF, 32'h0807_0605});
        exp_rd_q.push_back(15'd0); exp_rd_q.push_back(15'd1);
        done_snap = done_cnt;
        do_start(15'd0, 15'd2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_done(20);
        checks += 4;
        if (d_ok !== 1'b1 || d_err !== 1'b0) begin
            failures++; $display("FAIL basic_status ok/err got=%b/%b required=1/0", d_ok, d_err);
        end
        if (d_ww !== 16'd2) begin
            failures++; $display("FAIL basic_words_written got=%0d required=2", d_ww);
        end
        if (act_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_write_count got=%0d required=%0d", act_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic_write%0d got=%h required=%h", i, act_q[i], exp_q[i]);
            end
        end
        if (act_rd_q.size() != exp_rd_q.size()) begin
            failures++; $display("FAIL basic_read_count got=%0d required=%0d", act_rd_q.size(), exp_rd_q.size());
        end else foreach (exp_rd_q[i]) begin
            checks++;
            if (act_rd_q[i] !== exp_rd_q[i]) begin
                failures++; $display("FAIL basic_read%0d got=%0d required=%0d", i, act_rd_q[i], exp_rd_q[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - done_snap != 1) begin
            failures++; $display("FAIL basic_done_pulse done=%b busy=%b pulses=%0d required=0/0/1",
                                 done, busy, done_cnt - done_snap);
        end
        // Idle: offered bytes are not taken and results hold.
        in_valid = 1'b1; in_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || ok !== 1'b1 || words_written !== 16'd2) begin
                failures++; $display("FAIL idle_hold in_ready/ok/ww got=%b/%b/%0d required=0/1/2",
                                     in_ready, ok, words_written);
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_partial();
        logic [7:0] bytes [0:4];
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD; bytes[4] = 8'hEE;
        clear_logs();
        exp_q.push_back({15'd4, 4'hF, 32'hDDCC_BBAA});
        exp_q.push_back({15'd5, 4'h1, 32'h0000_00EE});
        exp_rd_q.push_back(15'd4); exp_rd_q.push_back(15'd5);
        do_start(15'd4, 15'd4);
        for (int i = 0; i < 5; i++) send_byte(bytes[i], i == 4);
        wait_done(20);
        checks += 3;
        if (d_ok !== 1'b1 || d_err !== 1'b0) begin
            failures++; $display("FAIL partial_status ok/err got=%b/%b required=1/0", d_ok, d_err);
        end
        if (d_ww !== 16'd2) begin
            failures++; $display("FAIL partial_words_written got=%0d required=2", d_ww);
        end
        if (act_q.size() != exp_q.size() || act_rd_q.size() != exp_rd_q.size()) begin
            failures++; $display("FAIL partial_access_count writes=%0d reads=%0d required=2/2",
                                 act_q.size(), act_rd_q.size());
        end else foreach (exp_q[i]) begin
            checks += 2;
            if (act_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL partial_write%0d got=%h required=%h", i, act_q[i], exp_q[i]);
            end
            if (act_rd_q[i] !== exp_rd_q[i]) begin
                failures++; $display("FAIL partial_read%0d got=%0d required=%0d", i, act_rd_q[i], exp_rd_q[i]);
            end
        end
    endtask

    task automatic test_range();
        // Both rejected ranges: past the top, and a zero count.
        for (int k = 0; k < 2; k++) begin
            cs_snap = cs_cnt;
            if (k == 0) do_start(15'd24999, 15'd2);
            else        do_start(15'd0, 15'd0);
            wait_done(5);
            checks += 2;
            if (d_err !== 1'b1 || d_ok !== 1'b0 || d_ww !== '0) begin
                failures++; $display("FAIL range_err%0d err/ok/ww got=%b/%b/%0d required=1/0/0",
                                     k, d_err, d_ok, d_ww);
            end
            if (cs_cnt != cs_snap) begin
                failures++; $display("FAIL range_no_access%0d chipselects=%0d required=0", k, cs_cnt - cs_snap);
            end
        end
        // Last legal range ends exactly at DEPTH-1.
        clear_logs();
        exp_q.push_back({15'd24998, 4'hF, 32'h1312_1110});
        exp_q.push_back({15'd24999, 4'hF, 32'h1716_1514});
        do_start(15'd24998, 15'd2);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
        wait_done(20);
        checks += 2;
        if (d_ok !== 1'b1 || d_err !== 1'b0 || d_ww !== 16'd2) begin
            failures++; $display("FAIL range_top ok/err/ww got=%b/%b/%0d required=1/0/2", d_ok, d_err, d_ww);
        end
        if (act_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
            failures++; $display("FAIL range_top_writes count=%0d required=2 with addr 24998/24999", act_q.size());
        end
    endtask

    task automatic test_corrupt();
        clear_logs();
        corrupt_en = 1'b1; corrupt_addr = 15'd21;
        exp_q.push_back({15'd20, 4'hF, 32'h4433_2211});
        exp_q.push_back({15'd21, 4'hF, 32'h8877_6655});
        do_start(15'd20, 15'd2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11), i == 8);
        wait_done(20);
        corrupt_en = 1'b0;
        checks += 2;
        if (d_ok !== 1'b0 || d_err !== 1'b0 || d_ww !== 16'd2) begin
            failures++; $display("FAIL corrupt_status ok/err/ww got=%b/%b/%0d required=0/0/2", d_ok, d_err, d_ww);
        end
        if (act_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
            failures++; $display("FAIL corrupt_writes count=%0d required=2", act_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_start(15'd8, 15'd3);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        cs_snap = cs_cnt; done_snap = done_cnt;
        in_data = 8'h33; in_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if ({in_ready, busy, done, ok, err_range, mem_chipselect, mem_write} !== 7'b0 ||
            words_written !== '0 || state_dbg !== 3'd0) begin
            failures++; $display("FAIL midreset_outputs flags=%b ww=%0d state=%0d required=0/0/0",
                {in_ready, busy, done, ok, err_range, mem_chipselect, mem_write}, words_written, state_dbg);
        end
        if (mem_address !== '0 || mem_writedata !== 32'h0 || mem_byteenable !== 4'b0000) begin
            failures++; $display("FAIL midreset_mem_bus got=%h/%h/%b required=0/0/0000",
                                 mem_address, mem_writedata, mem_byteenable);
        end
        repeat (8) tick();
        checks++;
        if (cs_cnt != cs_snap || done_cnt != done_snap) begin
            failures++; $display("FAIL midreset_quiet chipselects=%0d dones=%0d required=0/0",
                                 cs_cnt - cs_snap, done_cnt - done_snap);
        end
        clear_logs();
        exp_q.push_back({15'd8, 4'hF, 32'h7766_5544});
        do_start(15'd8, 15'd1);
        for (int i = 0; i < 4; i++) send_byte(8'h44 + 8'(i * 8'h11), 1'b0);
        wait_done(20);
        checks += 2;
        if (d_ok !== 1'b1 || d_err !== 1'b0 || d_ww !== 16'd1) begin
            failures++; $display("FAIL midreset_rerun ok/err/ww got=%b/%b/%0d required=1/0/1", d_ok, d_err, d_ww);
        end
        if (act_q.size() != 1 || act_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL midreset_rerun_write count=%0d required=1 data=77665544", act_q.size());
        end
    endtask

    task automatic test_gap_start();
        clear_logs();
        exp_q.push_back({15'd12, 4'hF, 32'h0403_0201});
        exp_q.push_back({15'd13, 4'hF, 32'h0807_0605});
        done_snap = done_cnt;
        do_start(15'd12, 15'd2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        start = 1'b1; base_addr = 15'd0; word_count = 15'd0;
        tick();
        start = 1'b0;
        tick(); tick();
        for (int i = 3; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_done(20);
        checks += 3;
        if (d_ok !== 1'b1 || d_err !== 1'b0 || d_ww !== 16'd2) begin
            failures++; $display("FAIL gap_status ok/err/ww got=%b/%b/%0d required=1/0/2", d_ok, d_err, d_ww);
        end
        if (act_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
            failures++; $display("FAIL gap_writes count=%0d first=%h required=2 first=%h",
                                 act_q.size(), (act_q.size() > 0) ? act_q[0] : '0, exp_q[0]);
        end
        if (done_cnt - done_snap != 1) begin
            failures++; $display("FAIL gap_done_pulses got=%0d required=1", done_cnt - done_snap);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_range();
        test_corrupt();
        test_reset_mid();
        test_gap_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
